fifo_rr_scheduler: RTL and testbench

FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

---
 rtl/fifo_rr_scheduler_pkg.sv | 25 ++
 rtl/fifo_rr_scheduler_arbiter.sv | 47 ++++
 rtl/fifo_rr_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_scheduler_pkg.sv
// fifo_sched_pkg: shared types and helpers for the FIFO round-robin scheduler.
// Holds the scheduler FSM state encoding and the queue-index width function.

package fifo_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  // Burst counter width: BURST_LEN tops out at 255
  localparam int BURST_CNT_W = 8;

  // Width of a queue index: max(1, clog2(n))
  function automatic int qw_f(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_arbiter.sv
// rr_arbiter: purely combinational rotate-priority search.
// Picks the first set request bit scanning upward from i_ptr, wrapping N-1 to 0.
// o_grant is one-hot (all zero when nothing requests); o_idx is its binary index.

`default_nettype none

module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = qw_f(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_cand;
  logic          w_found;

  // Walk the N candidates in rotated order and keep the first requester
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      // One extra bit of headroom so the wrap works for non-power-of-two N
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_cand = w_sum[PW-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: drains NUM_Q synchronous FIFOs into a single valid/ready
// stream, serving up to BURST_LEN consecutive words per grant, round-robin.
// One word is in flight at a time (no skid buffer): read, capture, hand off.
//
// Build option FIFO_SCHED_PRIO0_EN: queue 0 wins every grant decision while it
// holds data; queues 1..NUM_Q-1 rotate among themselves. A running burst is
// never cut short by queue 0.
//
// state   | meaning
// IDLE    | waiting for any non-empty queue, pick grant from rr_ptr
// ISSUE   | one-cycle read strobe to the granted queue
// CAPTURE | queue read data is valid, load output registers
// OUT     | word presented, wait for m_ready; continue burst or rotate

`default_nettype none

module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_Q      = 4,
  parameter int BURST_LEN  = 4,
  localparam int QW = qw_f(NUM_Q)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_Q-1:0]            q_empty,
  output logic [NUM_Q-1:0]            q_rd_en,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_rd_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [QW-1:0]               m_qid
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [QW-1:0]          r_rr_ptr;
  logic [QW-1:0]          w_rr_ptr_nxt;
  logic [QW-1:0]          r_grant;
  logic [QW-1:0]          w_grant_nxt;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic [BURST_CNT_W-1:0] w_burst_cnt_nxt;
  logic                   r_m_valid;
  logic                   w_m_valid_nxt;
  logic                   w_load_out;
  logic [DATA_WIDTH-1:0]  r_m_data;
  logic [QW-1:0]          r_m_qid;

  logic [NUM_Q-1:0]       w_arb_req;
  logic [NUM_Q-1:0]       w_arb_grant;
  logic [QW-1:0]          w_arb_idx;
  logic [QW-1:0]          w_pick;
  logic                   w_any;
  logic                   w_rotate;
  logic [QW-1:0]          w_grant_inc;
  logic                   w_grant_empty;
  logic                   w_burst_more;
  logic [NUM_Q-1:0]       w_rd_en;
  logic [DATA_WIDTH-1:0]  w_q_data [NUM_Q];

  // Split the flat read-data bus into one word per queue
  for (genvar g = 0; g < NUM_Q; g++) begin : g_slice
    assign w_q_data[g] = q_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef FIFO_SCHED_PRIO0_EN
  // Queue 0 bypasses the rotation; the arbiter only sees queues 1..NUM_Q-1
  assign w_arb_req = {~q_empty[NUM_Q-1:1], 1'b0};
  assign w_any     = ~q_empty[0] | (|w_arb_grant);
  assign w_pick    = q_empty[0] ? w_arb_idx : '0;
  // Serving queue 0 leaves the rotation point of the others untouched
  assign w_rotate  = (r_grant != '0);
`else
  assign w_arb_req = ~q_empty;
  assign w_any     = |w_arb_grant;
  assign w_pick    = w_arb_idx;
  assign w_rotate  = 1'b1;
`endif

  rr_arbiter #(
    .N (NUM_Q)
  ) u_arb (
    .i_req   (w_arb_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  assign w_grant_empty = q_empty[r_grant];
  assign w_grant_inc   = (r_grant == QW'(NUM_Q-1)) ? '0 : r_grant + 1'b1;
  assign w_burst_more  = (({1'b0, r_burst_cnt} + (BURST_CNT_W+1)'(1)) <
                          (BURST_CNT_W+1)'(BURST_LEN)) && !w_grant_empty;

  // Next-state and control decode; every target defaults to hold
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_grant_nxt     = r_grant;
    w_burst_cnt_nxt = r_burst_cnt;
    w_m_valid_nxt   = r_m_valid;
    w_load_out      = 1'b0;
    w_rd_en         = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt     = w_pick;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Gate on the live empty flag so an empty queue is never popped
        if (!w_grant_empty) begin
          w_rd_en[r_grant] = 1'b1;
        end
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_load_out    = 1'b1;
        w_m_valid_nxt = 1'b1;
        w_state_nxt   = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          w_m_valid_nxt = 1'b0;
          if (w_burst_more) begin
            w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            w_state_nxt     = ST_ISSUE;
          end else begin
            if (w_rotate) begin
              w_rr_ptr_nxt = w_grant_inc;
            end
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant bookkeeping and output word registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_qid     <= '0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_m_valid   <= w_m_valid_nxt;
      if (w_load_out) begin
        r_m_data <= w_q_data[r_grant];
        r_m_qid  <= r_grant;
      end
    end
  end

  assign q_rd_en = w_rd_en;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_qid   = r_m_qid;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: two instances (BURST_LEN=4 and BURST_LEN=1),
// each fed by a small registered-read FIFO model. Scenario tables hold the
// words loaded and the words expected out; expected words go to a scoreboard
// and are checked as the DUT hands them off.

`timescale 1ns/1ps

module tb_fifo_rr_scheduler;

  logic clk = 1'b0;
  logic rst;

  logic [1:0][3:0]   qe;
  logic [1:0][3:0]   re;
  logic [1:0][127:0] rdd = '0;
  logic [1:0]        mv;
  logic [1:0]        mr;
  logic [1:0][31:0]  md;
  logic [1:0][1:0]   mq;

  logic [31:0] mem [2][4][64];
  int wr_ptr [2][4] = '{default: 0};
  int rd_ptr [2][4] = '{default: 0};

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [33:0] sb0[$];
  logic [33:0] sb1[$];
  int hs0[$];

  typedef struct {
    int          scen;
    int          dut;
    int          lq;
    logic [31:0] ld;
    int          eq;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_rr_scheduler #(.DATA_WIDTH(32), .NUM_Q(4), .BURST_LEN(4)) u_dut_b4 (
    .clk(clk), .rst(rst), .q_empty(qe[0]), .q_rd_en(re[0]), .q_rd_data(rdd[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .m_qid(mq[0]));

  fifo_rr_scheduler #(.DATA_WIDTH(32), .NUM_Q(4), .BURST_LEN(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .q_empty(qe[1]), .q_rd_en(re[1]), .q_rd_data(rdd[1]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .m_qid(mq[1]));

  // FIFO models: empty flag from pointers, registered read data
  for (genvar d = 0; d < 2; d++) begin : g_d
    for (genvar i = 0; i < 4; i++) begin : g_i
      assign qe[d][i] = (wr_ptr[d][i] == rd_ptr[d][i]);
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (re[d][i]) begin
          rdd[d][i*32 +: 32] <= mem[d][i][rd_ptr[d][i] & 63];
          rd_ptr[d][i]       <= rd_ptr[d][i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic push(input int d, input int q, input logic [31:0] v);
    mem[d][q][wr_ptr[d][q]] = v;
    wr_ptr[d][q] = wr_ptr[d][q] + 1;
  endtask

  task automatic expect_word(input int d, input int q, input logic [31:0] v);
    if (d == 0) sb0.push_back({q[1:0], v});
    else        sb1.push_back({q[1:0], v});
  endtask

  task automatic add(input int s, input int d, input int lq, input logic [31:0] ld,
                     input int eq, input logic [31:0] ed);
    vec_t v;
    v.scen = s; v.dut = d; v.lq = lq; v.ld = ld; v.eq = eq; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic run_scen(input int s);
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].scen == s) begin
        push(tbl[k].dut, tbl[k].lq, tbl[k].ld);
        expect_word(tbl[k].dut, tbl[k].eq, tbl[k].ed);
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d/%0d words still outstanding, required 0", nm, sb0.size(), sb1.size());
      sb0.delete();
      sb1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int L;
    int n;
    logic [31:0] ld0 [5];
    logic [31:0] ld2 [8];
    int lq0 [5];
    int lq2 [8];

    rst = 1'b1;
    mr  = 2'b11;

    // Scenario 0: only queue 2 holds A0..A5, burst of 4 then return to IDLE
    for (int k = 0; k < 6; k++) add(0, 0, 2, 32'hA0 + k, 2, 32'hA0 + k);

    // Scenario 1: all four queues loaded, BURST_LEN=1 instance
    lq0 = '{0, 1, 2, 3, 0};
    ld0 = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
`ifdef FIFO_SCHED_PRIO0_EN
    add(1, 1, lq0[0], ld0[0], 0, 32'hB0);
    add(1, 1, lq0[1], ld0[1], 0, 32'hB4);
    add(1, 1, lq0[2], ld0[2], 1, 32'hB1);
    add(1, 1, lq0[3], ld0[3], 2, 32'hB2);
    add(1, 1, lq0[4], ld0[4], 3, 32'hB3);
`else
    for (int k = 0; k < 5; k++) add(1, 1, lq0[k], ld0[k], lq0[k], ld0[k]);
`endif

    // Scenario 2: queue 0 with six words, queue 1 with two
    lq2 = '{0, 0, 0, 0, 0, 0, 1, 1};
    ld2 = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hD0, 32'hD1};
`ifdef FIFO_SCHED_PRIO0_EN
    for (int k = 0; k < 8; k++) add(2, 0, lq2[k], ld2[k], lq2[k], ld2[k]);
`else
    add(2, 0, lq2[0], ld2[0], 0, 32'hC0);
    add(2, 0, lq2[1], ld2[1], 0, 32'hC1);
    add(2, 0, lq2[2], ld2[2], 0, 32'hC2);
    add(2, 0, lq2[3], ld2[3], 0, 32'hC3);
    add(2, 0, lq2[4], ld2[4], 1, 32'hD0);
    add(2, 0, lq2[5], ld2[5], 1, 32'hD1);
    add(2, 0, lq2[6], ld2[6], 0, 32'hC4);
    add(2, 0, lq2[7], ld2[7], 0, 32'hC5);
`endif

    // Watchdog and handshake monitor
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      forever begin
        logic [33:0] e;
        bit have;
        @(negedge clk);
        if (!rst) begin
          for (int d = 0; d < 2; d++) begin
            if (re[d] != 4'b0) begin
              checks++;
              if (!$onehot(re[d]) || ((re[d] & qe[d]) != 4'b0) || mv[d]) begin
                errors++;
                $display("FAIL rd_en_legal dut%0d: q_rd_en=%b q_empty=%b m_valid=%b, required one-hot to a non-empty queue with no word pending",
                         d, re[d], qe[d], mv[d]);
              end
            end
            if (mv[d] && mr[d]) begin
              if (d == 0) hs0.push_back(cyc);
              have = 1'b0;
              e = '0;
              if (d == 0 && sb0.size() > 0) begin have = 1'b1; e = sb0.pop_front(); end
              if (d == 1 && sb1.size() > 0) begin have = 1'b1; e = sb1.pop_front(); end
              if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word dut%0d: got qid=%0d data=%0h, required no output", d, mq[d], md[d]);
              end else begin
                chk($sformatf("word_dut%0d", d), {30'b0, mq[d], md[d]}, {30'b0, e});
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {62'b0, mv}, 64'h0);
    chk("rst_rd_en", {56'b0, re}, 64'h0);
    chk("rst_data0", {32'b0, md[0]}, 64'h0);
    chk("rst_qid",   {60'b0, mq}, 64'h0);
    rst = 1'b0;

    // All queues empty: nothing happens for 20 cycles
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_rd_en", {56'b0, re}, 64'h0);
      chk("idle_valid", {62'b0, mv}, 64'h0);
    end

    // Scenario 0 with timing: latency 3, 3 cycles/word, one IDLE cycle at burst end
    @(posedge clk); #1;
    L = cyc;
    hs0.delete();
    run_scen(0);
    wait_drain("burst_q2");
    chk("burst_q2_count", 64'(hs0.size()), 64'd6);
    if (hs0.size() == 6) begin
      chk("latency",      64'(hs0[0] - L),      64'd3);
      chk("throughput",   64'(hs0[1] - hs0[0]), 64'd3);
      chk("burst_rotate", 64'(hs0[4] - hs0[3]), 64'd4);
    end

    // Scenario 1: BURST_LEN=1 rotation
    @(posedge clk); #1;
    run_scen(1);
    wait_drain("rotate_b1");

    // Scenario 2: queue 0 and queue 1 competing
    @(posedge clk); #1;
    run_scen(2);
    wait_drain("q0_q1");

    // Backpressure: m_ready low for 10 cycles while a word is pending
    @(posedge clk); #1;
    mr[0] = 1'b0;
    push(0, 1, 32'hE0);
    push(0, 1, 32'hE1);
    expect_word(0, 1, 32'hE0);
    expect_word(0, 1, 32'hE1);
    n = 0;
    while (!mv[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {63'b0, mv[0]}, 64'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {25'b0, mv[0], re[0], mq[0], md[0]}, {25'b0, 1'b1, 4'b0, 2'd1, 32'hE0});
    end
    @(posedge clk); #1;
    mr[0] = 1'b1;
    wait_drain("backpressure");

    // Reset during CAPTURE: popped word lost, restart from rr_ptr=0
    @(posedge clk); #1;
    push(0, 3, 32'hF0);
    push(0, 3, 32'hF1);
    push(0, 0, 32'h50);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'b0, mv[0]}, 64'h0);
    chk("arst_data",  {32'b0, md[0]}, 64'h0);
    chk("arst_qid",   {62'b0, mq[0]}, 64'h0);
    chk("arst_rd_en", {60'b0, re[0]}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef FIFO_SCHED_PRIO0_EN
    expect_word(0, 3, 32'hF0);
    expect_word(0, 3, 32'hF1);
`else
    expect_word(0, 0, 32'h50);
    expect_word(0, 3, 32'hF1);
`endif
    wait_drain("reset_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
